// File: rtl/demux_pkg.sv
// Shared constants, FSM state type and route decode for the 1-to-4 packet demux.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;
  localparam logic [SEL_W-1:0] DEFAULT_CH = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } demux_state_t;

  // Same mapping as the 4:1 mux: sel 0..2 with en=1 pick that channel,
  // every other combination falls through to the default channel.
  function automatic logic [SEL_W-1:0] decode_dest(input logic en,
                                                   input logic [SEL_W-1:0] sel);
    return (en && (sel != 2'b11)) ? sel : DEFAULT_CH;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register for a single demux channel: holds data/last while
// valid, drains on consumer ready, and accepts a new word in the drain cycle.
module demux_out_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         din_last,
  input  logic         dout_ready,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic         dout_last
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;

  // Next-state: load wins over drain so a same-cycle drain+load stays valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load) begin
      data_d  = din;
      last_d  = din_last;
      valid_d = 1'b1;
    end else if (valid_q && dout_ready) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign dout       = data_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-4 packet demultiplexer: the route chosen on the first beat
// is held for the rest of the packet; each channel has a one-entry output slot.
module demux_router
  import demux_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W-1:0]        x,
  input  logic                x_valid,
  input  logic                x_last,
  output logic                x_ready,
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic [NUM_CH*W-1:0] out,
  output logic [NUM_CH-1:0]   out_valid,
  output logic [NUM_CH-1:0]   out_last,
  input  logic [NUM_CH-1:0]   out_ready,
  output logic                busy,
  output logic [SEL_W-1:0]    lock_dest
);

  demux_state_t      state_q, state_d;
  logic [SEL_W-1:0]  lock_dest_q, lock_dest_d;
  logic              busy_q, busy_d;
  logic [SEL_W-1:0]  dest;
  logic              accept;
  logic [NUM_CH-1:0] load;

  // Destination decode, input handshake and per-channel load strobes.
  always_comb begin
    dest    = (state_q == LOCKED) ? lock_dest_q : decode_dest(en, sel);
    x_ready = !out_valid[dest] || out_ready[dest];
    accept  = x_valid && x_ready;
    load    = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      load[c] = accept && (dest == SEL_W'(c));
    end
  end

  // Packet-lock FSM next state.
  always_comb begin
    state_d     = state_q;
    lock_dest_d = lock_dest_q;
    busy_d      = busy_q;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!x_last) begin
            state_d     = LOCKED;
            lock_dest_d = dest;
            busy_d      = 1'b1;
          end
        end
        LOCKED: begin
          if (x_last) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_dest_q <= DEFAULT_CH;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_dest_q <= lock_dest_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign lock_dest = lock_dest_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_slot
    demux_out_slot #(.W(W)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (load[c]),
      .din        (x),
      .din_last   (x_last),
      .dout_ready (out_ready[c]),
      .dout       (out[c*W +: W]),
      .dout_valid (out_valid[c]),
      .dout_last  (out_last[c])
    );
  end

endmodule

// File: tb/tb_demux_router.sv
// Self-checking bench for demux_router: per-channel scoreboard queues filled on
// accepted input beats and emptied as each channel hands a word to its consumer.
module tb_demux_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  x;
  logic        x_valid;
  logic        x_last;
  logic        x_ready;
  logic [1:0]  sel;
  logic        en;
  logic [31:0] out;
  logic [3:0]  out_valid;
  logic [3:0]  out_last;
  logic [3:0]  out_ready;
  logic        busy;
  logic [1:0]  lock_dest;

  int checks = 0;
  int errors = 0;

  // expected {last, data} per channel
  logic [8:0] exp_q [4][$];
  logic       m_locked;
  int         m_ch;

  demux_router #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .x_valid   (x_valid),
    .x_last    (x_last),
    .x_ready   (x_ready),
    .sel       (sel),
    .en        (en),
    .out       (out),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .lock_dest (lock_dest)
  );

  always #5 clk = ~clk;

  // One clock cycle: scoreboard bookkeeping at the falling edge, then return
  // 1 time unit after the rising edge so the caller sees updated outputs.
  task automatic tick();
    int ch;
    logic [8:0] e;
    @(negedge clk);
    if (rst) begin
      for (int c = 0; c < 4; c++) exp_q[c].delete();
      m_locked = 1'b0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          checks++;
          if (exp_q[c].size() == 0) begin
            errors++;
            $display("FAIL drain_ch%0d: got word %h last %b, required no word", c, out[c*8 +: 8], out_last[c]);
          end else begin
            e = exp_q[c].pop_front();
            if ({out_last[c], out[c*8 +: 8]} !== e) begin
              errors++;
              $display("FAIL drain_ch%0d: got last/data %b/%h, required %b/%h", c, out_last[c], out[c*8 +: 8], e[8], e[7:0]);
            end
          end
        end
      end
      if (x_valid && x_ready) begin
        ch = m_locked ? m_ch : ((en && sel != 2'b11) ? int'(sel) : 3);
        exp_q[ch].push_back({x_last, x});
        if (!m_locked && !x_last) begin
          m_locked = 1'b1;
          m_ch     = ch;
        end else if (m_locked && x_last) begin
          m_locked = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic l, input logic [1:0] s, input logic e);
    x = d; x_last = l; sel = s; en = e; x_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({out, out_valid, out_last, busy, lock_dest, x_ready} !== {32'h0, 4'h0, 4'h0, 1'b0, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got out=%h v=%b l=%b busy=%b lock=%0d rdy=%b, required 0/0000/0000/0/3/1",
               out, out_valid, out_last, busy, lock_dest, x_ready);
    end
  endtask

  task automatic test_single_beat();
    drive(8'hA5, 1'b1, 2'd1, 1'b1);
    tick();
    x_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0010 || out[15:8] !== 8'hA5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_ch1: got v=%b d=%h busy=%b, required 0010/a5/0", out_valid, out[15:8], busy);
    end
    tick();
    drive(8'h3C, 1'b1, 2'd0, 1'b0);
    tick();
    x_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b1000 || out[31:24] !== 8'h3C) begin
      errors++;
      $display("FAIL en0_ch3: got v=%b d=%h, required 1000/3c", out_valid, out[31:24]);
    end
    tick();
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++;
      $display("FAIL drained_idle: got v=%b, required 0000", out_valid);
    end
  endtask

  task automatic test_packet_lock();
    drive(8'h11, 1'b0, 2'd2, 1'b1);
    tick();
    checks++;
    if (busy !== 1'b1 || lock_dest !== 2'd2 || out_valid !== 4'b0100 || out_last[2] !== 1'b0) begin
      errors++;
      $display("FAIL pkt_beat1: got busy=%b lock=%0d v=%b l2=%b, required 1/2/0100/0", busy, lock_dest, out_valid, out_last[2]);
    end
    drive(8'h22, 1'b0, 2'd0, 1'b0);
    tick();
    checks++;
    if (busy !== 1'b1 || out_valid !== 4'b0100 || out[23:16] !== 8'h22 || out_last[2] !== 1'b0) begin
      errors++;
      $display("FAIL pkt_beat2: got busy=%b v=%b d=%h l2=%b, required 1/0100/22/0", busy, out_valid, out[23:16], out_last[2]);
    end
    drive(8'h33, 1'b1, 2'd0, 1'b0);
    tick();
    x_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 4'b0100 || out[23:16] !== 8'h33 || out_last[2] !== 1'b1 || lock_dest !== 2'd2) begin
      errors++;
      $display("FAIL pkt_beat3: got busy=%b v=%b d=%h l2=%b lock=%0d, required 0/0100/33/1/2", busy, out_valid, out[23:16], out_last[2], lock_dest);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1100;
    drive(8'h77, 1'b1, 2'd1, 1'b1);
    tick();
    drive(8'h5A, 1'b1, 2'd0, 1'b1);
    tick();
    drive(8'h6B, 1'b1, 2'd0, 1'b1);
    checks++;
    if (x_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall: got x_ready=%b, required 0", x_ready);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 4'b0011 || out[7:0] !== 8'h5A || out[15:8] !== 8'h77 || x_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: got v=%b d0=%h d1=%h rdy=%b, required 0011/5a/77/0", out_valid, out[7:0], out[15:8], x_ready);
    end
    out_ready = 4'b1110;
    tick();
    checks++;
    if (out_valid !== 4'b0001 || out[7:0] !== 8'h5A || x_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_other_drain: got v=%b d0=%h rdy=%b, required 0001/5a/0", out_valid, out[7:0], x_ready);
    end
    out_ready = 4'b1111;
    #1;
    checks++;
    if (x_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got x_ready=%b, required 1", x_ready);
    end
    tick();
    x_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0001 || out[7:0] !== 8'h6B) begin
      errors++;
      $display("FAIL bp_next_word: got v=%b d0=%h, required 0001/6b", out_valid, out[7:0]);
    end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    drive(8'hC1, 1'b0, 2'd2, 1'b1);
    tick();
    x_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_locked: got busy=%b, required 1", busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 4'b0000 || busy !== 1'b0 || lock_dest !== 2'd3) begin
      errors++;
      $display("FAIL rstmid_state: got v=%b busy=%b lock=%0d, required 0000/0/3", out_valid, busy, lock_dest);
    end
    drive(8'hD4, 1'b1, 2'd1, 1'b1);
    tick();
    x_valid = 1'b0;
    checks++;
    if (out_valid !== 4'b0010 || out[15:8] !== 8'hD4) begin
      errors++;
      $display("FAIL rstmid_first_beat: got v=%b d1=%h, required 0010/d4", out_valid, out[15:8]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(8'hE0 + 8'(i), (i == 3), (i == 0) ? 2'd2 : 2'd3, 1'b1);
      checks++;
      if (x_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d: got x_ready=%b, required 1", i, x_ready);
      end
      tick();
      checks++;
      if (out_valid !== 4'b0100 || out[23:16] !== 8'hE0 + 8'(i)) begin
        errors++;
        $display("FAIL b2b_out%0d: got v=%b d2=%h, required 0100/%h", i, out_valid, out[23:16], 8'hE0 + 8'(i));
      end
    end
    x_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_unlock: got busy=%b, required 0", busy);
    end
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; x = '0; x_valid = 1'b0; x_last = 1'b0; sel = '0; en = 1'b0;
    out_ready = 4'b1111; m_locked = 1'b0; m_ch = 0;
    test_reset();
    test_single_beat();
    test_packet_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_back_to_back();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (exp_q[c].size() != 0) begin
        errors++;
        $display("FAIL leftover_ch%0d: got %0d undelivered words, required 0", c, exp_q[c].size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
